// File: rtl/hsv_colour_bbox_if.sv
// Pixel-in / result-out bundle for hsv_colour_bbox.
//   master: pixel source and result consumer (drives pixels, window, out_ready)
//   slave : the bbox block (drives out_valid and result fields)
// Signals
//   in_valid, in_sop, h, s, v     pixel beat (no backpressure)
//   h_lo..v_hi                    inclusive H/S/V window (hue may wrap)
//   out_ready                     result accept
//   out_valid, found, x_min..y_max, pix_count, overrun   frame result
interface hsv_colour_bbox_if #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int H_W     = 10,
  parameter int S_W     = 18,
  parameter int V_W     = 10
);
  localparam int XW = $clog2(IMAGE_W);
  localparam int YW = $clog2(IMAGE_H);
  localparam int CW = $clog2(IMAGE_W*IMAGE_H+1);

  logic           in_valid;
  logic           in_sop;
  logic [H_W-1:0] h, h_lo, h_hi;
  logic [S_W-1:0] s, s_lo, s_hi;
  logic [V_W-1:0] v, v_lo, v_hi;
  logic           out_ready;
  logic           out_valid;
  logic           found;
  logic [XW-1:0]  x_min, x_max;
  logic [YW-1:0]  y_min, y_max;
  logic [CW-1:0]  pix_count;
  logic           overrun;

  modport master (
    output in_valid, in_sop, h, s, v, h_lo, h_hi, s_lo, s_hi, v_lo, v_hi, out_ready,
    input  out_valid, found, x_min, x_max, y_min, y_max, pix_count, overrun
  );
  modport slave (
    input  in_valid, in_sop, h, s, v, h_lo, h_hi, s_lo, s_hi, v_lo, v_hi, out_ready,
    output out_valid, found, x_min, x_max, y_min, y_max, pix_count, overrun
  );
endinterface

// File: rtl/hsv_colour_bbox.sv
// Per-frame colour blob detector on a raster HSV stream.
// Each pixel is tested against an H/S/V window (hue window may wrap); matching
// pixels are counted and their bounding box tracked. One registered result per
// completed frame, held until accepted.
// Ports
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    hsv_colour_bbox_if.slave: pixel beats, window, result handshake
module hsv_colour_bbox #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int MIN_COUNT = 16,
  parameter int H_W       = 10,
  parameter int S_W       = 18,
  parameter int V_W       = 10
) (
  input  logic            clk,
  input  logic            reset,
  hsv_colour_bbox_if.slave bus
);
  localparam int XW = $clog2(IMAGE_W);
  localparam int YW = $clog2(IMAGE_H);
  localparam int CW = $clog2(IMAGE_W*IMAGE_H+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IMAGE_W*IMAGE_H);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x_cnt, x_nxt, px;
  logic [YW-1:0] y_cnt, y_nxt, py;
  logic          beat, last;

  // Frame-scoped window copies; the sop pixel itself uses the live inputs.
  logic [H_W-1:0] h_lo_r, h_hi_r, h_lo_c, h_hi_c;
  logic [S_W-1:0] s_lo_r, s_hi_r, s_lo_c, s_hi_c;
  logic [V_W-1:0] v_lo_r, v_hi_r, v_lo_c, v_hi_c;
  logic           hue_ok, match;

  // Stage 1
  logic          s1_vld, s1_first, s1_match;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic [1:0]    last_pipe;   // [1] = commit this edge

  // Stage 2 accumulators
  logic          have;
  logic [CW-1:0] acc_cnt;
  logic [XW-1:0] acc_xmn, acc_xmx;
  logic [YW-1:0] acc_ymn, acc_ymx;
  logic          found_c;

  // ---------------- raster FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      state <= state_nxt;
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    // sop always restarts at (0,0), aborting any frame in progress
    px   = bus.in_sop ? '0 : x_cnt;
    py   = bus.in_sop ? '0 : y_cnt;
    beat = bus.in_valid && (bus.in_sop || state == FRAME);
    last = beat && px == XW'(IMAGE_W-1) && py == YW'(IMAGE_H-1);
    if (beat) begin
      state_nxt = last ? IDLE : FRAME;
      if (px == XW'(IMAGE_W-1)) begin
        x_nxt = '0;
        y_nxt = last ? '0 : py + YW'(1);
      end else begin
        x_nxt = px + XW'(1);
        y_nxt = py;
      end
    end
  end

  // ---------------- window ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {h_lo_r, h_hi_r, s_lo_r, s_hi_r, v_lo_r, v_hi_r} <= '0;
    end else if (bus.in_valid && bus.in_sop) begin
      h_lo_r <= bus.h_lo; h_hi_r <= bus.h_hi;
      s_lo_r <= bus.s_lo; s_hi_r <= bus.s_hi;
      v_lo_r <= bus.v_lo; v_hi_r <= bus.v_hi;
    end
  end

  always_comb begin
    h_lo_c = bus.in_sop ? bus.h_lo : h_lo_r;
    h_hi_c = bus.in_sop ? bus.h_hi : h_hi_r;
    s_lo_c = bus.in_sop ? bus.s_lo : s_lo_r;
    s_hi_c = bus.in_sop ? bus.s_hi : s_hi_r;
    v_lo_c = bus.in_sop ? bus.v_lo : v_lo_r;
    v_hi_c = bus.in_sop ? bus.v_hi : v_hi_r;
    // h_lo > h_hi selects the wrap-around (red) hue band
    hue_ok = (h_lo_c <= h_hi_c) ? (bus.h >= h_lo_c && bus.h <= h_hi_c)
                                : (bus.h >= h_lo_c || bus.h <= h_hi_c);
    match  = hue_ok && bus.s >= s_lo_c && bus.s <= s_hi_c
                    && bus.v >= v_lo_c && bus.v <= v_hi_c;
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_first  <= 1'b0;
      s1_match  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      last_pipe <= '0;
    end else begin
      s1_vld    <= beat;
      s1_first  <= beat && bus.in_sop;
      s1_match  <= match;
      s1_x      <= px;
      s1_y      <= py;
      last_pipe <= {last_pipe[0], last};
    end
  end

  // ---------------- stage 2 ----------------
  // The first pixel of a frame reinitialises everything, which is also how an
  // aborted frame's partial sums are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have    <= 1'b0;
      acc_cnt <= '0;
      acc_xmn <= '0; acc_xmx <= '0;
      acc_ymn <= '0; acc_ymx <= '0;
    end else if (s1_vld) begin
      if (s1_match && (s1_first || !have)) begin
        acc_xmn <= s1_x; acc_xmx <= s1_x;
        acc_ymn <= s1_y; acc_ymx <= s1_y;
      end else if (s1_match) begin
        if (s1_x < acc_xmn) acc_xmn <= s1_x;
        if (s1_x > acc_xmx) acc_xmx <= s1_x;
        if (s1_y < acc_ymn) acc_ymn <= s1_y;
        if (s1_y > acc_ymx) acc_ymx <= s1_y;
      end
      if (s1_first) begin
        have    <= s1_match;
        acc_cnt <= CW'(s1_match);
      end else if (s1_match) begin
        have    <= 1'b1;
        acc_cnt <= (acc_cnt < CNT_MAX) ? acc_cnt + CW'(1) : acc_cnt;
      end
    end
  end

  // ---------------- result register ----------------
  assign found_c = acc_cnt >= CW'(MIN_COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.found     <= 1'b0;
      bus.x_min     <= '0; bus.x_max <= '0;
      bus.y_min     <= '0; bus.y_max <= '0;
      bus.pix_count <= '0;
    end else if (last_pipe[1]) begin
      // a commit coinciding with acceptance is a clean handover, not an overrun
      bus.out_valid <= 1'b1;
      bus.overrun   <= bus.out_valid && !bus.out_ready;
      bus.found     <= found_c;
      bus.x_min     <= (found_c && have) ? acc_xmn : '0;
      bus.x_max     <= (found_c && have) ? acc_xmx : '0;
      bus.y_min     <= (found_c && have) ? acc_ymn : '0;
      bus.y_max     <= (found_c && have) ? acc_ymx : '0;
      bus.pix_count <= acc_cnt;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end
  end
endmodule
